// File: rtl/binary_to_onehot_pipe_pkg.sv
// Shared definitions for the 2-to-4 one-hot decode pipeline: occupancy states
// and the one-hot words produced for each input code.
package binary_to_onehot_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    // One-hot words in encoder order: z1 <-> 00, z2 <-> 01, z3 <-> 10, z4 <-> 11
    localparam logic [3:0] OH_Z1 = 4'b0001;
    localparam logic [3:0] OH_Z2 = 4'b0010;
    localparam logic [3:0] OH_Z3 = 4'b0100;
    localparam logic [3:0] OH_Z4 = 4'b1000;

    localparam int FIFO_DEPTH = 2;

    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        logic [3:0] word;
        word = OH_Z1;
        case (code)
            2'b00:   word = OH_Z1;
            2'b01:   word = OH_Z2;
            2'b10:   word = OH_Z3;
            2'b11:   word = OH_Z4;
            default: word = OH_Z1;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/binary_to_onehot_pipe_code2onehot.sv
// Purely combinational 2-to-4 decode; bit1 of the code is A (MSB), bit0 is B.
module code2onehot
    import binary_to_onehot_pipe_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [3:0] onehot_o
);

    always_comb begin
        onehot_o = code_to_onehot(code_i);
    end

endmodule

// File: rtl/binary_to_onehot_pipe.sv
// Valid/ready 2-to-4 decoder with a 2-entry in-order FIFO of decoded words.
// Handshake outputs are registered from the occupancy state only.
module binary_to_onehot_pipe
    import binary_to_onehot_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_onehot,
    output logic [CNT_W-1:0] dec_count,
    output logic             busy
);

    occ_state_e       state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [CNT_W-1:0] dec_count_q;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [3:0]       dec_word;
    logic             push;
    logic             pop;

    // Reset blocks any handshake so nothing is written, read or counted.
    assign push = in_valid & in_ready_q & ~rst;
    assign pop  = out_valid_q & out_ready & ~rst;

    code2onehot u_dec (
        .code_i   (in_code),
        .onehot_o (dec_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            dec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            if (push) begin
                wr_ptr_q    <= ~wr_ptr_q;
                dec_count_q <= dec_count_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Storage carries no reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_word;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = out_valid_q;
    assign dec_count  = dec_count_q;
    assign out_onehot = out_valid_q ? mem_q[rd_ptr_q] : 4'b0000;

endmodule

// File: tb/tb_binary_to_onehot_pipe.sv
// Directed bench for binary_to_onehot_pipe with a default-width instance and a
// 4-bit-counter instance sharing the same stimulus.
module tb_binary_to_onehot_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_code;
    logic        out_ready;

    logic        in_ready, out_valid, busy;
    logic [3:0]  out_onehot;
    logic [15:0] dec_count;

    logic        in_ready4, out_valid4, busy4;
    logic [3:0]  out_onehot4;
    logic [3:0]  dec_count4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    binary_to_onehot_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .dec_count  (dec_count),
        .busy       (busy)
    );

    binary_to_onehot_pipe #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .in_code    (in_code),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_onehot (out_onehot4),
        .dec_count  (dec_count4),
        .busy       (busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'b11;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (out_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot got=%b want=0000", out_onehot); end
        checks++;
        if (dec_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", dec_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_decode();
        logic [1:0] codes [4];
        logic [3:0] exp   [4];
        codes[0] = 2'b00; exp[0] = 4'b0001;
        codes[1] = 2'b01; exp[1] = 4'b0010;
        codes[2] = 2'b10; exp[2] = 4'b0100;
        codes[3] = 2'b11; exp[3] = 4'b1000;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = codes[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== exp[i]) begin
                errors++;
                $display("FAIL decode_%0d got=%b/%b want=1/%b", i, out_valid, out_onehot, exp[i]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL decode_pop_%0d valid=%b busy=%b want=0/0", i, out_valid, busy);
            end
        end
        checks++;
        if (dec_count !== 16'd4) begin errors++; $display("FAIL decode_count got=%0d want=4", dec_count); end
    endtask

    task automatic test_full();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'b11;
        tick();
        checks++;
        if (out_onehot !== 4'b1000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_first got=%b rdy=%b want=1000/1", out_onehot, in_ready);
        end
        in_code = 2'b10;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 4'b1000) begin
            errors++;
            $display("FAIL full_state rdy=%b vld=%b oh=%b want=0/1/1000", in_ready, out_valid, out_onehot);
        end
        in_code = 2'b01;
        tick();
        checks++;
        if (dec_count !== 16'd2 || out_onehot !== 4'b1000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_drop cnt=%0d oh=%b rdy=%b want=2/1000/0", dec_count, out_onehot, in_ready);
        end
    endtask

    task automatic test_pop_full();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_onehot !== 4'b0100 || in_ready !== 1'b1 || dec_count !== 16'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pop_full oh=%b rdy=%b cnt=%0d vld=%b want=0100/1/2/1",
                     out_onehot, in_ready, dec_count, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (dec_count !== 16'd3 || in_ready !== 1'b0 || out_onehot !== 4'b0100) begin
            errors++;
            $display("FAIL refill cnt=%0d rdy=%b oh=%b want=3/0/0100", dec_count, in_ready, out_onehot);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_onehot !== 4'b0010) begin errors++; $display("FAIL drain_second got=%b want=0010", out_onehot); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_onehot !== 4'b0000) begin
            errors++;
            $display("FAIL drain_empty vld=%b oh=%b want=0/0000", out_valid, out_onehot);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] codes [4];
        logic [3:0] exp   [4];
        codes[0] = 2'b00; exp[0] = 4'b0001;
        codes[1] = 2'b01; exp[1] = 4'b0010;
        codes[2] = 2'b10; exp[2] = 4'b0100;
        codes[3] = 2'b11; exp[3] = 4'b1000;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = codes[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_onehot !== exp[i]) begin
                errors++;
                $display("FAIL b2b_%0d vld=%b rdy=%b oh=%b want=1/1/%b", i, out_valid, in_ready, out_onehot, exp[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || dec_count !== 16'd4) begin
            errors++;
            $display("FAIL b2b_end vld=%b cnt=%0d want=0/4", out_valid, dec_count);
        end
    endtask

    task automatic test_ignore_idle();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_code = 2'(i);
            tick();
        end
        checks++;
        if (dec_count !== 16'd4 || out_valid !== 1'b0 || out_onehot !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ignore cnt=%0d vld=%b oh=%b want=4/0/0000", dec_count, out_valid, out_onehot);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        in_valid = 1'b1;
        in_code  = 2'b01;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_setup rdy=%b want=0", in_ready); end
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || dec_count !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstfull vld=%b oh=%b cnt=%0d rdy=%b want=0/0000/0/1",
                     out_valid, out_onehot, dec_count, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstfull_after vld=%b busy=%b want=0/0", out_valid, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_code = 2'(i % 4);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_busy busy4=%b busy=%b want=1/1", busy4, busy);
        end
        checks++;
        if (dec_count4 !== 4'd1) begin errors++; $display("FAIL wrap_count4 got=%0d want=1", dec_count4); end
        checks++;
        if (dec_count !== 16'd17) begin errors++; $display("FAIL wrap_count16 got=%0d want=17", dec_count); end
        checks++;
        if (out_onehot4 !== 4'b0001) begin errors++; $display("FAIL wrap_last got=%b want=0001", out_onehot4); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'b00;
        out_ready = 1'b0;
        test_reset();
        test_decode();
        test_ignore_idle();
        test_full();
        test_pop_full();
        test_back_to_back();
        test_reset_full();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/binary_to_onehot_pipe.md
BINARY_TO_ONEHOT_PIPE -- requirements
Module: binary_to_onehot_pipe

Interface
REQ-001 Parameter: CNT_W, default 16, width of the accepted-word counter dec_count.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream offers in_code this cycle.
REQ-005 Port: in_ready  output  1  block can accept a word this cycle.
REQ-006 Port: in_code  input  2  binary code; bit1 = A (MSB), bit0 = B (LSB).
REQ-007 Port: out_valid  output  1  out_onehot holds a valid decoded word.
REQ-008 Port: out_ready  input  1  downstream consumes the word this cycle.
REQ-009 Port: out_onehot  output  4  one-hot word; bit0 = z1, bit1 = z2, bit2 = z3, bit3 = z4.
REQ-010 Port: dec_count  output  CNT_W  number of words accepted since reset.
REQ-011 Port: busy  output  1  high whenever the buffer holds at least one word.

Function
REQ-012 Decode map SHALL be 00->0001, 01->0010, 10->0100, 11->1000, the exact inverse of the team's 4-to-2 encoder (z1->00, z2->01, z3->10, z4->11).
REQ-013 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high; it SHALL be dropped otherwise.
REQ-014 Storage SHALL be a 2-entry in-order FIFO of decoded 4-bit words (decode at write time).
REQ-015 Occupancy FSM SHALL have states EMPTY, ONE, FULL; push-only advances (EMPTY->ONE->FULL), pop-only retreats (FULL->ONE->EMPTY), push+pop in ONE stays in ONE.
REQ-016 in_ready SHALL be high in EMPTY and ONE, low in FULL, and SHALL be a registered function of state only (no combinational path from out_ready).
REQ-017 out_valid SHALL be high in ONE and FULL; a pop occurs on an edge where out_valid and out_ready are both high.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N is presented with out_valid high from edge N (visible in cycle N+1); no same-cycle bypass when EMPTY.
REQ-019 out_onehot SHALL be the head entry when out_valid is high and 4'b0000 when out_valid is low.
REQ-020 out_onehot and out_valid SHALL remain stable while out_valid is high and out_ready is low.
REQ-021 In FULL with out_ready high, one word SHALL pop and in_ready SHALL go high the following cycle; no push occurs in that same cycle.
REQ-022 Read and write pointers SHALL be 1 bit each and wrap 1->0.
REQ-023 dec_count SHALL increment by 1 per accepted word, wrap from 2^CNT_W-1 to 0, and never count pops.
REQ-024 busy SHALL equal out_valid.
REQ-025 in_code SHALL be ignored when in_valid is low; the values of in_code that are not accepted SHALL have no effect.

Reset
REQ-026 While rst is high at a rising edge: FSM = EMPTY, pointers = 0, dec_count = 0, in_ready = 1, out_valid = 0, out_onehot = 0000, busy = 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; a handshake in the reset cycle SHALL neither push, pop, nor count.
REQ-028 in_ready SHALL be high in the first cycle after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (EMPTY, ONE, FULL) and the four one-hot constants for z1..z4.
REQ-030 The 2-to-4 combinational decode SHALL be a sub-module code2onehot (in 2 bits, out 4 bits), instantiated once at the FIFO write port.

Verification
REQ-031 Reset then push codes 00,01,10,11 with out_ready=1 -> out_onehot 0001,0010,0100,1000 in order, each one cycle after acceptance; dec_count=4.
REQ-032 out_ready=0, push 11 then 10 -> FULL, in_ready=0, third offer (01) not accepted, out_onehot holds 1000; dec_count=2.
REQ-033 From FULL, raise out_ready for one cycle -> 1000 popped, next out_onehot=0100, in_ready=1 the following cycle.
REQ-034 In ONE with in_valid=1 and out_ready=1 for 4 cycles with codes 00,01,10,11 -> state stays ONE, outputs follow in order, no drops.
REQ-035 Assert rst while FULL with in_valid=1 and out_ready=1 -> after reset out_valid=0, out_onehot=0000, dec_count=0, in_ready=1.
REQ-036 Run with CNT_W=4, push 17 words -> dec_count reads 1 (wrap).
